// File: rtl/mips_prog_encoder_pkg.sv
// Shared definitions for the MIPS program loader.
// - Symbolic instruction kinds accepted on the input stream.
// - The six primary opcodes, matching the values the main decoder recognises.
// - FSM state encoding for the loader session.
// - A legality check and the instruction encoder used by the top level.
package mips_prog_encoder_pkg;

  localparam int INSN_W = 32;

  localparam logic [2:0] KIND_RTYPE = 3'd0;
  localparam logic [2:0] KIND_LW    = 3'd1;
  localparam logic [2:0] KIND_SW    = 3'd2;
  localparam logic [2:0] KIND_BEQ   = 3'd3;
  localparam logic [2:0] KIND_ADDI  = 3'd4;
  localparam logic [2:0] KIND_J     = 3'd5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic kind_legal(input logic [2:0] kind);
    return (kind <= KIND_J);
  endfunction

  // Builds the 32-bit instruction word; shamt is always zero. Illegal kinds
  // yield zero, but the caller never pushes them.
  function automatic logic [INSN_W-1:0] encode_insn(
    input logic [2:0]  kind,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [5:0]  funct,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [INSN_W-1:0] w;
    w = '0;
    case (kind)
      KIND_RTYPE: w = {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
      KIND_LW:    w = {OP_LW,   rs, rt, imm};
      KIND_SW:    w = {OP_SW,   rs, rt, imm};
      KIND_BEQ:   w = {OP_BEQ,  rs, rt, imm};
      KIND_ADDI:  w = {OP_ADDI, rs, rt, imm};
      KIND_J:     w = {OP_J,    target};
      default:    w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mips_prog_encoder_fifo.sv
// prog_fifo: synchronous FIFO holding encoded instruction words.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (pointers/count only)
//   push, wdata write side; a push while full is taken only if a pop frees a slot
//   pop, rdata  read side; rdata shows the head word whenever !empty
//   full, empty occupancy flags
module prog_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mips_prog_encoder.sv
// mips_prog_encoder: program loader that encodes symbolic MIPS instructions
// (RTYPE, LW, SW, BEQ, ADDI, J) and writes them into instruction memory.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, base_addr      session start pulse (IDLE only) and first word address
//   in_valid/in_ready     input handshake; in_kind, in_last, in_rs, in_rt, in_rd,
//                         in_funct, in_imm, in_target carry the instruction fields
//   imem_we/imem_ready    imem write request held until accepted
//   imem_addr, imem_wdata write address and encoded word
//   busy, done            session active / one-cycle completion pulse
//   wr_count              words written in the current/last session
//   err_kind, err_wrap    sticky illegal-kind and address-wrap flags
module mips_prog_encoder
  import mips_prog_encoder_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic              in_last,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_count,
  output logic              err_kind,
  output logic              err_wrap
);

  state_e            state;
  state_e            state_nxt;
  logic              accept;
  logic              vld_p0;
  logic [INSN_W-1:0] word_p0;
  logic [INSN_W-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              wr_done;

  assign in_ready = (state == ST_LOAD) && !fifo_full;
  assign accept   = in_valid && in_ready;
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign wr_done  = imem_we && imem_ready;
  // Refill the output register when it is empty or its word is leaving.
  assign fifo_pop = !fifo_empty && (!imem_we || imem_ready);

  // Stage p0: combinational encode of the accepted fields; illegal kinds are dropped.
  assign vld_p0  = accept && kind_legal(in_kind);
  assign word_p0 = encode_insn(in_kind, in_rs, in_rt, in_rd, in_funct, in_imm, in_target);

  prog_fifo #(
    .DATA_W (INSN_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (vld_p0),
    .wdata (word_p0),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_LOAD;
      ST_LOAD:  if (accept && in_last) state_nxt = ST_DRAIN;
      ST_DRAIN: if (fifo_empty && !imem_we) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Stage p1: imem output register; holds word and request while imem stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_we    <= 1'b0;
      imem_wdata <= '0;
    end else if (fifo_pop) begin
      imem_we    <= 1'b1;
      imem_wdata <= fifo_rdata;
    end else if (wr_done) begin
      imem_we    <= 1'b0;
    end
  end

  // imem_addr doubles as the session address counter: it only advances when a
  // write completes, so it stays stable for the whole duration of a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_addr <= '0;
      wr_count  <= '0;
      err_kind  <= 1'b0;
      err_wrap  <= 1'b0;
    end else if ((state == ST_IDLE) && start) begin
      imem_addr <= base_addr;
      wr_count  <= '0;
      err_kind  <= 1'b0;
      err_wrap  <= 1'b0;
    end else begin
      if (wr_done) begin
        imem_addr <= imem_addr + 1'b1;
        wr_count  <= wr_count + 1'b1;
        if (&imem_addr) err_wrap <= 1'b1;
      end
      if (accept && !kind_legal(in_kind)) err_kind <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_prog_encoder.sv
// Self-checking bench for mips_prog_encoder: directed scenarios plus randomized
// sessions, with expected imem writes kept in a queue built from the
// instruction-format rules.
module tb_mips_prog_encoder;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2:0]        in_kind = '0;
  logic              in_last = 1'b0;
  logic [4:0]        in_rs = '0;
  logic [4:0]        in_rt = '0;
  logic [4:0]        in_rd = '0;
  logic [5:0]        in_funct = '0;
  logic [15:0]       in_imm = '0;
  logic [25:0]       in_target = '0;
  logic              imem_we;
  logic              imem_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   wr_count;
  logic              err_kind;
  logic              err_wrap;

  logic fixed_rdy = 1'b1;
  logic rand_rdy_en = 1'b0;
  logic rnd_rdy = 1'b1;
  assign imem_ready = rand_rdy_en ? rnd_rdy : fixed_rdy;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [ADDR_W+31:0] exp_q[$];
  int                 comp_cyc[$];

  logic [ADDR_W-1:0] m_addr = '0;
  int                m_cnt = 0;
  logic              m_ek = 1'b0;
  logic              m_ew = 1'b0;

  logic              stall_prev = 1'b0;
  logic [ADDR_W-1:0] stall_addr = '0;
  logic [31:0]       stall_data = '0;

  mips_prog_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_kind    (in_kind),
    .in_last    (in_last),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_rd      (in_rd),
    .in_funct   (in_funct),
    .in_imm     (in_imm),
    .in_target  (in_target),
    .imem_we    (imem_we),
    .imem_ready (imem_ready),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .done       (done),
    .wr_count   (wr_count),
    .err_kind   (err_kind),
    .err_wrap   (err_wrap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every accepted imem write must match the queue head, and a
  // stalled request must hold its address and data.
  always @(negedge clk) begin
    logic [ADDR_W+31:0] e;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_we", imem_we, 1);
        check("hold_addr", imem_addr, stall_addr);
        check("hold_data", imem_wdata, stall_data);
      end
      if (imem_we && imem_ready) begin
        n_checks++;
        assert (exp_q.size() > 0) else begin
          n_fail++;
          $error("FAIL spurious_write: observed addr %0h data %0h expected no write", imem_addr, imem_wdata);
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("wr_addr", imem_addr, e[ADDR_W+31:32]);
          check("wr_data", imem_wdata, e[31:0]);
          comp_cyc.push_back(cyc);
        end
      end
      stall_prev = imem_we && !imem_ready;
      stall_addr = imem_addr;
      stall_data = imem_wdata;
    end
  end

  // MIPS formats: R = op|rs|rt|rd|shamt|funct, I = op|rs|rt|imm, J = op|target.
  function automatic logic [31:0] ref_encode(input logic [2:0] k, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn,
      input logic [15:0] imm, input logic [25:0] tgt);
    case (k)
      3'd0:    return {6'd0, rs, rt, rd, 5'd0, fn};
      3'd1:    return {6'd35, rs, rt, imm};
      3'd2:    return {6'd43, rs, rt, imm};
      3'd3:    return {6'd4, rs, rt, imm};
      3'd4:    return {6'd8, rs, rt, imm};
      3'd5:    return {6'd2, tgt};
      default: return 32'h0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic begin_session(input logic [ADDR_W-1:0] b);
    start = 1'b1;
    base_addr = b;
    tick();
    start = 1'b0;
    base_addr = ADDR_W'($urandom);
    m_addr = b;
    m_cnt = 0;
    m_ek = 1'b0;
    m_ew = 1'b0;
  endtask

  task automatic send(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
      input logic [4:0] rd, input logic [5:0] fn, input logic [15:0] imm,
      input logic [25:0] tgt, input logic last, input logic [32:0] exp_w);
    bit acc = 1'b0;
    logic [31:0] w;
    in_valid = 1'b1; in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd;
    in_funct = fn; in_imm = imm; in_target = tgt; in_last = last;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
    end
    in_valid = 1'b0;
    in_kind = 3'($urandom);
    in_last = 1'($urandom);
    in_imm = 16'($urandom);
    n_checks++;
    assert (acc) else begin
      n_fail++;
      $error("FAIL send_timeout: observed in_ready low for 300 cycles expected accept");
    end
    if (acc) begin
      if (k <= 3'd5) begin
        w = exp_w[32] ? exp_w[31:0] : ref_encode(k, rs, rt, rd, fn, imm, tgt);
        exp_q.push_back({m_addr, w});
        if (m_addr == {ADDR_W{1'b1}}) m_ew = 1'b1;
        m_addr = m_addr + 1'b1;
        m_cnt++;
      end else begin
        m_ek = 1'b1;
      end
    end
  endtask

  task automatic send_rand(input logic last, input int max_kind);
    send(3'($urandom_range(0, max_kind)), 5'($urandom), 5'($urandom), 5'($urandom),
         6'($urandom), 16'($urandom), 26'($urandom), last, 33'h0);
  endtask

  task automatic wait_done(input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      got = done;
    end
    n_checks++;
    assert (got) else begin
      n_fail++;
      $error("FAIL %s_done: observed no done pulse expected pulse", tag);
    end
    check({tag, "_wr_count"}, wr_count, 64'(m_cnt));
    check({tag, "_err_kind"}, err_kind, m_ek);
    check({tag, "_err_wrap"}, err_wrap, m_ew);
    check({tag, "_pending"}, 64'(exp_q.size()), 0);
    @(negedge clk);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_done_pulse"}, done, 0);
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_imem_we"}, imem_we, 0);
    check({tag, "_imem_addr"}, imem_addr, 0);
    check({tag, "_imem_wdata"}, imem_wdata, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_wr_count"}, wr_count, 0);
    check({tag, "_err_kind"}, err_kind, 0);
    check({tag, "_err_wrap"}, err_wrap, 0);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    check_all_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Single ADDI, two-cycle latency
    begin_session(8'h10);
    check("t1_busy", busy, 1);
    check("t1_in_ready", in_ready, 1);
    send(3'd4, 5'd0, 5'd8, 5'd0, 6'd0, 16'd5, 26'd0, 1'b1, {1'b1, 32'h20080005});
    @(negedge clk);
    check("t1_lat_we0", imem_we, 0);
    @(negedge clk);
    check("t1_lat_we1", imem_we, 1);
    check("t1_lat_addr", imem_addr, 8'h10);
    check("t1_lat_data", imem_wdata, 32'h20080005);
    wait_done("t1");

    // Four formats back to back, one write per cycle; mid-session start ignored
    comp_cyc.delete();
    begin_session(8'h50);
    send(3'd1, 5'd0, 5'd9, 5'd0, 6'd0, 16'h0004, 26'd0, 1'b0, {1'b1, 32'h8C090004});
    start = 1'b1;
    base_addr = 8'h80;
    send(3'd2, 5'd0, 5'd9, 5'd0, 6'd0, 16'h0008, 26'd0, 1'b0, {1'b1, 32'hAC090008});
    start = 1'b0;
    send(3'd3, 5'd8, 5'd9, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b0, {1'b1, 32'h1109FFFF});
    send(3'd5, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0000010, 1'b1, {1'b1, 32'h08000010});
    wait_done("t2");
    check("t2_nwrites", 64'(comp_cyc.size()), 4);
    for (int i = 1; i < comp_cyc.size(); i++)
      check("t2_one_per_cycle", 64'(comp_cyc[i] - comp_cyc[i-1]), 1);

    // imem stall: FIFO fills, in_ready drops after DEPTH+1 accepts
    begin_session(8'h40);
    fixed_rdy = 1'b0;
    send(3'd0, 5'd8, 5'd9, 5'd10, 6'h20, 16'd0, 26'd0, 1'b0, {1'b1, 32'h01095020});
    for (int i = 0; i < DEPTH; i++) send_rand(1'b0, 5);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t3_in_ready_low", in_ready, 0);
      check("t3_stall_we", imem_we, 1);
      check("t3_stall_addr", imem_addr, 8'h40);
      check("t3_stall_data", imem_wdata, 32'h01095020);
    end
    tick();
    fixed_rdy = 1'b1;
    send_rand(1'b1, 5);
    wait_done("t3");

    // Address wrap and an illegal kind mid-stream
    begin_session(8'hFE);
    send(3'd4, 5'd1, 5'd2, 5'd0, 6'd0, 16'h1234, 26'd0, 1'b0, 33'h0);
    send(3'd7, 5'd3, 5'd4, 5'd5, 6'd6, 16'h5555, 26'd0, 1'b0, 33'h0);
    send(3'd1, 5'd6, 5'd7, 5'd0, 6'd0, 16'h0010, 26'd0, 1'b0, 33'h0);
    send(3'd5, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h3ABCDEF, 1'b1, 33'h0);
    wait_done("t4");
    check("t4_err_wrap_set", err_wrap, 1);
    check("t4_err_kind_set", err_kind, 1);

    // Reset during DRAIN aborts the session; a fresh session starts clean
    begin_session(8'h20);
    check("t5_err_kind_clr", err_kind, 0);
    check("t5_err_wrap_clr", err_wrap, 0);
    check("t5_wr_count_clr", wr_count, 0);
    fixed_rdy = 1'b0;
    send(3'd4, 5'd1, 5'd1, 5'd0, 6'd0, 16'd1, 26'd0, 1'b0, 33'h0);
    send(3'd6, 5'd1, 5'd1, 5'd0, 6'd0, 16'd1, 26'd0, 1'b0, 33'h0);
    send(3'd4, 5'd2, 5'd2, 5'd0, 6'd0, 16'd2, 26'd0, 1'b1, 33'h0);
    tick();
    check("t5_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("t5_abort");
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    fixed_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t5_no_done", done, 0);
      check("t5_idle", busy, 0);
    end
    tick();
    begin_session(8'h30);
    send(3'd2, 5'd4, 5'd5, 5'd0, 6'd0, 16'h0C, 26'd0, 1'b0, 33'h0);
    send(3'd3, 5'd4, 5'd5, 5'd0, 6'd0, 16'hFFFE, 26'd0, 1'b1, 33'h0);
    wait_done("t5");

    // Randomized sessions with random imem back-pressure and illegal kinds
    rand_rdy_en = 1'b1;
    for (int s = 0; s < 8; s++) begin
      int n;
      n = $urandom_range(1, 9);
      begin_session((s == 0) ? 8'hFC : ADDR_W'($urandom));
      for (int i = 0; i < n; i++) send_rand(i == n - 1, 7);
      wait_done("rnd");
    end
    rand_rdy_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
